aes_cbc_dec_chain: RTL

- Sequential CBC-decrypt chaining controller. It sits directly upstream of the CBC decrypt stage, which is combinational: it takes ciphertext, key and IV and produces plaintext as core output XOR IV.
- Accepts a stream of 128-bit ciphertext blocks through a valid/ready handshake and holds key and ciphertext stable toward the stage.
- Drives the stage IV from a chaining register: the initial IV for the first block, then the previous ciphertext for each later block.
- Registers the returned plaintext onto a valid/ready output stream, with per-message framing by a last flag.

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_cbc_dec_chain.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the CBC-decrypt chaining controller.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/aes_cbc_dec_chain.sv
// CBC-decrypt chaining controller: feeds one ciphertext block at a time to a
// combinational decrypt stage, chains the IV from the previous ciphertext and
// registers the plaintext onto a valid/ready output stream.
// Optional: AES_CBC_BLKCNT_EN adds blk_cnt, the in-message index of m_data.
module aes_cbc_dec_chain
    import aes_pkg::*;
#(
    parameter int CORE_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_load,
    input  logic [AES_BLK_W-1:0] cfg_key,
    input  logic [AES_BLK_W-1:0] cfg_iv,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [AES_BLK_W-1:0] s_data,
    input  logic                 s_last,
    output logic [AES_BLK_W-1:0] dec_ct,
    output logic [AES_BLK_W-1:0] dec_key,
    output logic [AES_BLK_W-1:0] dec_iv,
    input  logic [AES_BLK_W-1:0] dec_pt,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [AES_BLK_W-1:0] m_data,
    output logic                 m_last
`ifdef AES_CBC_BLKCNT_EN
    ,
    output logic [15:0]          blk_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CORE_LAT - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   last_q, last_d;
    logic [AES_BLK_W-1:0]   ct_q, ct_d;
    logic [AES_BLK_W-1:0]   key_q, key_d;
    logic [AES_BLK_W-1:0]   iv_q, iv_d;
    logic [AES_BLK_W-1:0]   mdata_q, mdata_d;
    logic                   mlast_q, mlast_d;
    logic                   mvalid_q, mvalid_d;
    logic                   sready_q, sready_d;

    // Next-state and datapath updates for the IDLE/RUN/WAIT/HOLD sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        ct_d     = ct_q;
        key_d    = key_q;
        iv_d     = iv_q;
        mdata_d  = mdata_q;
        mlast_d  = mlast_q;
        mvalid_d = mvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_load) begin
                    key_d   = cfg_key;
                    iv_d    = cfg_iv;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (s_valid && sready_q) begin
                    ct_d    = s_data;
                    last_d  = s_last;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mdata_d  = dec_pt;
                    mlast_d  = last_q;
                    mvalid_d = 1'b1;
                    iv_d     = ct_q;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    mvalid_d = 1'b0;
                    state_d  = last_q ? ST_IDLE : ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        sready_d = (state_d == ST_RUN);
    end

    // Register all state and outputs; asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            ct_q     <= '0;
            key_q    <= '0;
            iv_q     <= '0;
            mdata_q  <= '0;
            mlast_q  <= 1'b0;
            mvalid_q <= 1'b0;
            sready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            ct_q     <= ct_d;
            key_q    <= key_d;
            iv_q     <= iv_d;
            mdata_q  <= mdata_d;
            mlast_q  <= mlast_d;
            mvalid_q <= mvalid_d;
            sready_q <= sready_d;
        end
    end

    assign s_ready = sready_q;
    assign dec_ct  = ct_q;
    assign dec_key = key_q;
    assign dec_iv  = iv_q;
    assign m_valid = mvalid_q;
    assign m_data  = mdata_q;
    assign m_last  = mlast_q;

`ifdef AES_CBC_BLKCNT_EN
    logic [15:0] blk_q, blk_d;

    // Block index: cleared by an accepted cfg_load, advanced per output handshake.
    always_comb begin
        blk_d = blk_q;
        if (state_q == ST_IDLE && cfg_load) begin
            blk_d = '0;
        end else if (mvalid_q && m_ready) begin
            blk_d = blk_q + 16'd1;
        end
    end

    // Block index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q <= '0;
        end else begin
            blk_q <= blk_d;
        end
    end

    assign blk_cnt = blk_q;
`endif

endmodule
